// File: rtl/fifo_out.sv
// Registered status/strobe decoder for the FIFO: one clock from state/data_count to every flag.
// No backpressure: outputs are recomputed on every clock and never stall.
module fifo_out #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       state,
    input  logic [CNT_W-1:0] data_count,
    output logic             full,
    output logic             empty,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             rd_ack,
    output logic             rd_err
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'b000,
        ST_WRITE  = 3'b001,
        ST_READ   = 3'b010,
        ST_NO_OP  = 3'b011,
        ST_WR_ERR = 3'b101,
        ST_RD_ERR = 3'b110
    } fifo_state_e;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic full_nxt;
    logic empty_nxt;
    logic wr_ack_nxt;
    logic wr_err_nxt;
    logic rd_ack_nxt;
    logic rd_err_nxt;

    // Unused codes 100/111 fall into the default branch and behave as NO_OP.
    always_comb begin
        full_nxt   = (data_count >= DEPTH_C);
        empty_nxt  = (data_count == '0);
        wr_ack_nxt = 1'b0;
        wr_err_nxt = 1'b0;
        rd_ack_nxt = 1'b0;
        rd_err_nxt = 1'b0;
        case (state)
            ST_WRITE:  wr_ack_nxt = 1'b1;
            ST_READ:   rd_ack_nxt = 1'b1;
            ST_WR_ERR: wr_err_nxt = 1'b1;
            ST_RD_ERR: rd_err_nxt = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= 1'b0;
            empty  <= 1'b1;
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
            rd_ack <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            full   <= full_nxt;
            empty  <= empty_nxt;
            wr_ack <= wr_ack_nxt;
            wr_err <= wr_err_nxt;
            rd_ack <= rd_ack_nxt;
            rd_err <= rd_err_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_out.sv
// Directed bench for fifo_out; output vector order is {full, empty, wr_ack, wr_err, rd_ack, rd_err}.
module tb_fifo_out;

    logic       clk;
    logic       rst;
    logic [2:0] state;
    logic [3:0] data_count;
    logic       full;
    logic       empty;
    logic       wr_ack;
    logic       wr_err;
    logic       rd_ack;
    logic       rd_err;

    int n_assert = 0;
    int n_fail   = 0;
    logic [5:0] prev_exp;

    localparam logic [5:0] RST_V = 6'b010000;

    fifo_out #(.DEPTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .data_count (data_count),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {full, empty, wr_ack, wr_err, rd_ack, rd_err};
    endfunction

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        logic       one_hot;
        obs = outs();
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        one_hot = ($countones(obs[3:0]) <= 1);
        n_assert++;
        assert (one_hot === 1'b1) else begin
            n_fail++;
            $error("FAIL %s_onehot: observed strobes %b expected at most one high", tag, obs[3:0]);
        end
    endtask

    // Apply inputs mid-cycle, confirm nothing moves before the edge, then check after it.
    task automatic step(input string tag, input logic [2:0] st, input logic [3:0] cnt,
                        input logic [5:0] exp);
        state      = st;
        data_count = cnt;
        #1;
        check({tag, "_hold"}, prev_exp);
        @(posedge clk);
        #1;
        check(tag, exp);
        prev_exp = exp;
    endtask

    initial begin
        rst        = 1'b1;
        state      = 3'b000;
        data_count = 4'd0;
        #2;
        check("reset_no_clk", RST_V);

        // Reset must hold across a clock edge even with active inputs.
        state      = 3'b001;
        data_count = 4'd8;
        @(posedge clk);
        #1;
        check("reset_held_edge", RST_V);
        prev_exp = RST_V;
        rst = 1'b0;

        step("init_empty",    3'b000, 4'd0, 6'b010000);
        step("write_cnt1",    3'b001, 4'd1, 6'b001000);
        step("write_cnt8",    3'b001, 4'd8, 6'b101000);
        step("read_cnt8",     3'b010, 4'd8, 6'b100010);
        step("read_cnt0",     3'b010, 4'd0, 6'b010010);
        step("noop_cnt0",     3'b011, 4'd0, 6'b010000);
        step("noop_cnt8",     3'b011, 4'd8, 6'b100000);
        step("unused100",     3'b100, 4'd3, 6'b000000);
        step("unused111",     3'b111, 4'd0, 6'b010000);
        step("wr_err_cnt8",   3'b101, 4'd8, 6'b100100);
        step("rd_err_cnt0",   3'b110, 4'd0, 6'b010001);
        step("write_illegal", 3'b001, 4'd9, 6'b101000);
        step("write_cnt7",    3'b001, 4'd7, 6'b001000);

        // wr_ack is high now; reset between edges must clear it immediately.
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", RST_V);
        @(posedge clk);
        #1;
        check("async_reset_held", RST_V);
        prev_exp = RST_V;
        rst = 1'b0;

        step("read_after_rst", 3'b010, 4'd4, 6'b000010);
        step("init_cnt8",      3'b000, 4'd8, 6'b100000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
